// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 control sequencer: walks fetch/decode/execute/memory/
// writeback states per opcode and drives every datapath select and enable.
// Memory states stall on mem_ready so one memory serves instructions and data.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | after reset, all outputs quiet
// FETCH    | read instruction at PC, PC+4 -> PC and IR load on mem_ready
// DECODE   | precompute branch target, dispatch on opcode
// MEMADDR  | compute A + sign-extended imm for lw/sw
// MEMREAD  | data read at ALUOut, wait for mem_ready
// MEMWB    | write MDR into rt
// MEMWRITE | data write at ALUOut, wait for mem_ready
// EXEC     | R-type ALU operation on A, B with funct
// RWB      | write ALUOut into rd
// BRANCH   | compare A - B, load branch target if zero
// JUMP     | load jump target into PC
// ADDIEX   | A + sign-extended imm
// ADDIWB   | write ALUOut into rt
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [STATE_W-1:0] S_IDLE     = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMADDR  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXEC     = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_RWB      = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_ADDIEX   = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_ADDIWB   = STATE_W'(12);

    logic [STATE_W-1:0] next_state;

    // State register; reset wins over any in-flight instruction or memory wait.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state selection; unused encodings fall back to IDLE.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:     next_state = S_FETCH;
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            // opcode is held by the IR here, so anything not lw is treated as sw
            S_MEMADDR:  next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC:     next_state = S_RWB;
            S_RWB:      next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_ADDIEX:   next_state = S_ADDIWB;
            S_ADDIWB:   next_state = S_FETCH;
            default:    next_state = S_IDLE;
        endcase
    end

    // Datapath controls; everything defaults to 0 so idle states stay quiet.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // PC and IR only load once the instruction word is actually there
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default:                                      illegal_op = 1'b1;
                endcase
            end
            S_MEMADDR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: each instruction is expanded into its
// expected state path from the opcode, stalls are inserted in the memory-wait
// states, and per-cycle outputs are compared against a per-state control table.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op};

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Control table from the state descriptions.
    function automatic logic [16:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
        logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ao, ps;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
            2:  begin sb = 2'b11; ill = !is_legal(op); end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
    endfunction

    // Runs one instruction starting in FETCH; fstall/mstall are the number of
    // mem_ready=0 cycles in FETCH and in the data-memory state.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        int path[$];
        path = {1, 2};
        case (op)
            6'b000000: path = {path, 7, 8};
            6'b100011: path = {path, 3, 4, 5};
            6'b101011: path = {path, 3, 6};
            6'b000100: path = {path, 9};
            6'b000010: path = {path, 10};
            6'b001000: path = {path, 11, 12};
            default:   ;
        endcase
        foreach (path[i]) begin
            int  st;
            bit  stallable;
            int  n;
            logic rdy;
            st = path[i];
            stallable = (st == 1 || st == 4 || st == 6);
            n = !stallable ? 0 : (st == 1 ? fstall : mstall);
            for (int k = 0; k <= n; k++) begin
                rdy = stallable ? (k == n) : 1'($urandom);
                opcode = (st == 1) ? 6'($urandom) : op;
                mem_ready = rdy;
                #1;
                checks++;
                if (state !== 4'(st)) begin
                    failures++;
                    $display("FAIL state op=%b step=%0d actual=%0d required=%0d", op, i, state, st);
                end
                checks++;
                if (outs !== exp_out(st, op, rdy)) begin
                    failures++;
                    $display("FAIL outputs op=%b state=%0d rdy=%b actual=%b required=%b",
                             op, st, rdy, outs, exp_out(st, op, rdy));
                end
                checks++;
                if ((mem_read && mem_write) || (reg_write && mem_write)) begin
                    failures++;
                    $display("FAIL exclusive_enables state=%0d actual=%b required=no overlap", st, outs);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = 6'($urandom);
        mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (state !== 4'd0 || outs !== 17'd0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d actual state=%0d outs=%b required state=0 outs=0", c, state, outs);
            end
        end
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || outs !== 17'd0) begin
            failures++;
            $display("FAIL idle actual state=%0d outs=%b required state=0 outs=0", state, outs);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd1 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL after_reset actual state=%0d mem_read=%b required state=1 mem_read=1", state, mem_read);
        end
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr(6'b100011, 0, 3);
    endtask

    task automatic test_fetch_stall();
        run_instr(6'b000000, 2, 0);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0);
        #1;
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL illegal_return actual=%0d required=1", state);
        end
    endtask

    task automatic test_reset_mid_memwrite();
        opcode = 6'b101011;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd6 || mem_write !== 1'b1) begin
            failures++;
            $display("FAIL memwrite_entry actual state=%0d mem_write=%b required state=6 mem_write=1", state, mem_write);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_memwrite actual state=%0d mem_write=%b required state=0 mem_write=0", state, mem_write);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL refetch_after_reset actual=%0d required=1", state);
        end
    endtask

    task automatic test_branch_jump();
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 1, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b101011, 0, 2);
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_fetch_stall();
        test_illegal();
        test_branch_jump();
        test_reset_mid_memwrite();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS32 datapath.
- Decodes the instruction opcode and steps through fetch, decode, execute, memory and writeback states.
- Drives every datapath select line: ALU operand muxes, writeback-source mux, destination-register mux, PC source, and memory/register write enables.
- Stalls on a memory ready handshake so multi-cycle memories can be shared for instruction and data access.

Parameters:
- STATE_W, 4, width of the state register and the debug state output

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26], taken from the instruction register
- mem_ready  input  1  memory has completed the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (beq)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback mux select: 1=MDR, 0=ALUOut
- reg_dst  output  1  destination mux select: 1=rd instr[15:11], 0=rt instr[20:16]
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0=PC, 1=register A
- alu_src_b  output  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  output  2  00=add, 01=sub, 10=use funct field
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
- state  output  STATE_W  current state, for debug

Behaviour:
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5
  - MEMWRITE=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12
  - Encodings 13-15 are unused and map to IDLE on the next edge.
- Reset:
  - rst=1 at a clock edge forces state=IDLE. This takes priority over everything, including mid-instruction and mid-memory-wait.
  - In IDLE every output is 0, including illegal_op. state=0.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - pc_write and ir_write are asserted only while mem_ready=1 (Mealy qualification).
  - The FSM holds in FETCH while mem_ready=0; it goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target is precomputed).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 (lw) and 101011 (sw) -> MEMADDR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - any other opcode -> FETCH, with illegal_op=1 for this DECODE cycle only
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw (opcode is held stable by the IR).
- MEMREAD: mem_read=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWRITE: mem_write=1, iord=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- Output defaults:
  - Any output not listed for a state is 0.
  - mem_read and mem_write are never both 1.
  - reg_write and mem_write are never both 1.
- Latency with mem_ready tied to 1 (FETCH through the final state):
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- Opcode changes are only sampled in DECODE and MEMADDR.

Test Plan:
- rst=1 for 2 cycles, then released -> state=0 and all outputs 0 during reset; state=1 one cycle after release; mem_read=1.
- mem_ready=1, opcode=000000 -> states 1,2,7,8,1. In state 8: reg_write=1, reg_dst=1, mem_to_reg=0. In state 7: alu_op=10.
- opcode=100011, mem_ready held 0 for 3 cycles in MEMREAD -> state sequence 1,2,3,4,4,4,4,5,1 (4 held for 3 stall cycles plus the completing cycle). In MEMREAD: iord=1, mem_read=1. In MEMWB: mem_to_reg=1, reg_write=1.
- mem_ready=0 for 2 cycles in FETCH -> pc_write=0 and ir_write=0 while stalled. Both are 1 only in the cycle mem_ready=1; the next state is DECODE.
- opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE; next state is FETCH; reg_write, mem_write and pc_write remain 0.
- rst=1 asserted during MEMWRITE while mem_ready=0 -> state=IDLE next edge and mem_write=0. beq and j sequences: BRANCH gives pc_write_cond=1, pc_source=01; JUMP gives pc_write=1, pc_source=10.
